// File: rtl/ahb_burst_master_ctrl_pkg.sv
// Shared AHB encodings, sequencer state codes and the burst-length helper
// for ahb_burst_master_ctrl (package name: ahb_pkg).
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    typedef logic [2:0] seq_state_t;
    localparam seq_state_t ST_IDLE  = 3'd0;
    localparam seq_state_t ST_REQ   = 3'd1;
    localparam seq_state_t ST_ADDR  = 3'd2;
    localparam seq_state_t ST_LAST  = 3'd3;
    localparam seq_state_t ST_ABORT = 3'd4;

    function automatic logic [7:0] burst_beats(input logic [2:0] burst, input logic [7:0] len);
        case (burst)
            HBURST_SINGLE:               return 8'd1;
            HBURST_INCR:                 return len + 8'd1;
            HBURST_INCR4, HBURST_WRAP4:  return 8'd4;
            HBURST_INCR8, HBURST_WRAP8:  return 8'd8;
            default:                     return 8'd16;
        endcase
    endfunction

    function automatic logic burst_is_wrap(input logic [2:0] burst);
        return (burst == HBURST_WRAP4) || (burst == HBURST_WRAP8) || (burst == HBURST_WRAP16);
    endfunction

endpackage

// File: rtl/ahb_burst_master_ctrl_if.sv
// Command port plus AHB master-side signals of ahb_burst_master_ctrl.
// "master" is the sequencer's view, "slave" the view of the bus/client side.
interface ahb_burst_master_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 5
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_burst;
    logic [2:0]        cmd_size;
    logic              cmd_write;
    logic [LEN_W-1:0]  cmd_len;

    logic              Hbusreq;
    logic              Hgrant;
    logic              Hready;
    logic [1:0]        Hresp;
    logic [ADDR_W-1:0] Haddr;
    logic [1:0]        Htrans;
    logic [2:0]        Hburst;
    logic [2:0]        Hsize;
    logic              Hwrite;

    logic [4:0]        beat_idx;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len,
        input  Hgrant, Hready, Hresp,
        output cmd_ready, Hbusreq, Haddr, Htrans, Hburst, Hsize, Hwrite,
        output beat_idx, done, err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_burst, cmd_size, cmd_write, cmd_len,
        output Hgrant, Hready, Hresp,
        input  cmd_ready, Hbusreq, Haddr, Htrans, Hburst, Hsize, Hwrite,
        input  beat_idx, done, err
    );
endinterface

// File: rtl/ahb_burst_master_ctrl_addr_gen.sv
// ahb_addr_gen: current/next beat address and remaining-beat counter.
// Wrap addressing is built only when AHB_SEQ_WRAP_EN is defined.
module ahb_addr_gen
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [2:0]        load_size,
    input  logic [7:0]        load_beats,
`ifdef AHB_SEQ_WRAP_EN
    input  logic              load_wrap,
`endif
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] next_addr,
    output logic              next_cross_1k,
    output logic [7:0]        remaining
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [7:0]        rem_q, rem_d;
    logic [ADDR_W-1:0] incr_addr;

    assign incr_addr = addr_q + (ADDR_W'(1) << size_q);

`ifdef AHB_SEQ_WRAP_EN
    logic              wrap_q, wrap_d;
    logic [ADDR_W-1:0] mask_q, mask_d;

    assign next_addr = wrap_q ? ((addr_q & ~mask_q) | (incr_addr & mask_q)) : incr_addr;
`else
    assign next_addr = incr_addr;
`endif

    assign next_cross_1k = (next_addr[9:0] == 10'd0);
    assign addr          = addr_q;
    assign remaining     = rem_q;

    always_comb begin
        addr_d = addr_q;
        size_d = size_q;
        rem_d  = rem_q;
`ifdef AHB_SEQ_WRAP_EN
        wrap_d = wrap_q;
        mask_d = mask_q;
`endif
        if (load) begin
            addr_d = load_addr;
            size_d = load_size;
            rem_d  = load_beats;
`ifdef AHB_SEQ_WRAP_EN
            wrap_d = load_wrap;
            mask_d = (ADDR_W'(load_beats) << load_size) - ADDR_W'(1);
`endif
        end else if (advance) begin
            addr_d = next_addr;
            rem_d  = rem_q - 8'd1;
        end
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            addr_q <= '0;
            size_q <= '0;
            rem_q  <= '0;
`ifdef AHB_SEQ_WRAP_EN
            wrap_q <= 1'b0;
            mask_q <= '0;
`endif
        end else begin
            addr_q <= addr_d;
            size_q <= size_d;
            rem_q  <= rem_d;
`ifdef AHB_SEQ_WRAP_EN
            wrap_q <= wrap_d;
            mask_q <= mask_d;
`endif
        end
    end

endmodule

// File: rtl/ahb_burst_master_ctrl.sv
// AHB master transfer sequencer: command port in, registered AHB address phase out.
// AHB_SEQ_WRAP_EN enables WRAP4/8/16; otherwise WRAP commands complete with err.
//   state    | meaning
//   IDLE     | ready for a command
//   REQ      | bus requested, waiting for Hgrant && Hready
//   ADDR     | beats being issued in address phase
//   LAST     | final data phase in progress
//   ABORT    | second cycle of an ERROR response
module ahb_burst_master_ctrl
    import ahb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 5
) (
    input logic                     Hclk,
    input logic                     Hresetn,
    ahb_burst_master_ctrl_if.master bus
);

`ifdef AHB_SEQ_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    seq_state_t        state_q, state_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [2:0]        hsize_q, hsize_d;
    logic              hwrite_q, hwrite_d;
    logic              hbusreq_q, hbusreq_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [4:0]        beat_idx_q, beat_idx_d;
    logic              dphase_q, dphase_d;
    logic              rebuild_q, rebuild_d;
    logic [2:0]        cmd_burst_q, cmd_burst_d;
    logic [2:0]        cmd_size_q, cmd_size_d;
    logic              cmd_write_q, cmd_write_d;

    logic [LEN_W-1:0]  cmd_len;
    logic              accept;
    logic              cmd_ok;
    logic              bus_err;
    logic [2:0]        rebuild_burst;
    logic              ag_load;
    logic              ag_advance;
    logic [ADDR_W-1:0] ag_addr;
    logic [ADDR_W-1:0] ag_next_addr;
    logic              ag_next_cross_1k;
    logic [7:0]        ag_remaining;

    assign cmd_len = bus.cmd_len;
    assign accept  = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid;
    assign cmd_ok  = (bus.cmd_size <= 3'd2) && (WRAP_EN || !burst_is_wrap(bus.cmd_burst));
    // ERROR only counts while one of our own beats is in its data phase
    assign bus_err = dphase_q && (bus.Hresp == HRESP_ERROR) && !bus.Hready;
    assign rebuild_burst = (WRAP_EN && burst_is_wrap(cmd_burst_q)) ? HBURST_SINGLE : HBURST_INCR;

    ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .Hclk          (Hclk),
        .Hresetn       (Hresetn),
        .load          (ag_load),
        .load_addr     (bus.cmd_addr),
        .load_size     (bus.cmd_size),
        .load_beats    (burst_beats(bus.cmd_burst, 8'(cmd_len))),
`ifdef AHB_SEQ_WRAP_EN
        .load_wrap     (burst_is_wrap(bus.cmd_burst)),
`endif
        .advance       (ag_advance),
        .addr          (ag_addr),
        .next_addr     (ag_next_addr),
        .next_cross_1k (ag_next_cross_1k),
        .remaining     (ag_remaining)
    );

    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hburst_d    = hburst_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        hbusreq_d   = hbusreq_q;
        cmd_ready_d = cmd_ready_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        beat_idx_d  = beat_idx_q;
        rebuild_d   = rebuild_q;
        cmd_burst_d = cmd_burst_q;
        cmd_size_d  = cmd_size_q;
        cmd_write_d = cmd_write_q;
        dphase_d    = bus.Hready ? htrans_q[1] : dphase_q;
        ag_load     = 1'b0;
        ag_advance  = 1'b0;

        if (bus_err && (state_q == ST_REQ || state_q == ST_ADDR || state_q == ST_LAST)) begin
            state_d  = ST_ABORT;
            htrans_d = HTRANS_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_d = 1'b1;
                    if (accept) begin
                        cmd_ready_d = 1'b0;
                        cmd_burst_d = bus.cmd_burst;
                        cmd_size_d  = bus.cmd_size;
                        cmd_write_d = bus.cmd_write;
                        rebuild_d   = 1'b0;
                        beat_idx_d  = '0;
                        if (cmd_ok) begin
                            ag_load   = 1'b1;
                            hbusreq_d = 1'b1;
                            state_d   = ST_REQ;
                        end else begin
                            done_d = 1'b1;
                            err_d  = 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.Hgrant && bus.Hready) begin
                        state_d   = ST_ADDR;
                        htrans_d  = HTRANS_NONSEQ;
                        haddr_d   = ag_addr;
                        hburst_d  = rebuild_q ? rebuild_burst : cmd_burst_q;
                        hsize_d   = cmd_size_q;
                        hwrite_d  = cmd_write_q;
                        hbusreq_d = (ag_remaining != 8'd1);
                    end
                end
                ST_ADDR: begin
                    if (bus.Hready) begin
                        ag_advance = 1'b1;
                        if (ag_remaining == 8'd1) begin
                            state_d  = ST_LAST;
                            htrans_d = HTRANS_IDLE;
                        end else begin
                            beat_idx_d = beat_idx_q + 5'd1;
                            if (!bus.Hgrant) begin
                                state_d   = ST_REQ;
                                htrans_d  = HTRANS_IDLE;
                                hbusreq_d = 1'b1;
                                rebuild_d = 1'b1;
                            end else begin
                                haddr_d   = ag_next_addr;
                                hbusreq_d = (ag_remaining != 8'd2);
                                // rebuilt wrap beats go out as singles; INCR restarts at 1 KB
                                if (hburst_q == HBURST_SINGLE ||
                                    (hburst_q == HBURST_INCR && ag_next_cross_1k)) begin
                                    htrans_d = HTRANS_NONSEQ;
                                end else begin
                                    htrans_d = HTRANS_SEQ;
                                end
                            end
                        end
                    end
                end
                ST_LAST: begin
                    if (bus.Hready) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (bus.Hready) begin
                        done_d    = 1'b1;
                        err_d     = 1'b1;
                        hbusreq_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q     <= ST_IDLE;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hburst_q    <= '0;
            hsize_q     <= '0;
            hwrite_q    <= 1'b0;
            hbusreq_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            beat_idx_q  <= '0;
            dphase_q    <= 1'b0;
            rebuild_q   <= 1'b0;
            cmd_burst_q <= '0;
            cmd_size_q  <= '0;
            cmd_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hburst_q    <= hburst_d;
            hsize_q     <= hsize_d;
            hwrite_q    <= hwrite_d;
            hbusreq_q   <= hbusreq_d;
            cmd_ready_q <= cmd_ready_d;
            done_q      <= done_d;
            err_q       <= err_d;
            beat_idx_q  <= beat_idx_d;
            dphase_q    <= dphase_d;
            rebuild_q   <= rebuild_d;
            cmd_burst_q <= cmd_burst_d;
            cmd_size_q  <= cmd_size_d;
            cmd_write_q <= cmd_write_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.Hbusreq   = hbusreq_q;
    assign bus.Haddr     = haddr_q;
    assign bus.Htrans    = htrans_q;
    assign bus.Hburst    = hburst_q;
    assign bus.Hsize     = hsize_q;
    assign bus.Hwrite    = hwrite_q;
    assign bus.beat_idx  = beat_idx_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_ahb_burst_master_ctrl.sv
// Directed bench for ahb_burst_master_ctrl; WRAP expectations follow AHB_SEQ_WRAP_EN.
module tb_ahb_burst_master_ctrl;
    import ahb_pkg::*;

    logic Hclk = 1'b0;
    logic Hresetn;
    int   n_chk  = 0;
    int   n_fail = 0;

    ahb_burst_master_ctrl_if #(.ADDR_W(32), .LEN_W(5)) bus_if ();

    ahb_burst_master_ctrl #(.ADDR_W(32), .LEN_W(5)) dut (
        .Hclk    (Hclk),
        .Hresetn (Hresetn),
        .bus     (bus_if)
    );

    always #5 Hclk = ~Hclk;

    logic [31:0] i4_a   [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};
    logic [1:0]  i4_t   [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
    logic [31:0] incr_a [6] = '{32'h3F8, 32'h3FC, 32'h400, 32'h404, 32'h408, 32'h40C};
    logic [1:0]  incr_t [6] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
    logic [31:0] gl_a   [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C};
    logic [1:0]  gl_t   [8] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b11, 2'b11, 2'b11};
`ifdef AHB_SEQ_WRAP_EN
    logic [31:0] wr_a   [4] = '{32'h38, 32'h3C, 32'h30, 32'h34};
    logic [1:0]  wr_t   [4] = '{2'b10, 2'b11, 2'b11, 2'b11};
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic send_cmd(input logic [31:0] addr, input logic [2:0] burst, input logic [2:0] size,
                            input logic wr, input logic [4:0] len);
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_addr  = addr;
        bus_if.cmd_burst = burst;
        bus_if.cmd_size  = size;
        bus_if.cmd_write = wr;
        bus_if.cmd_len   = len;
        tick();
        bus_if.cmd_valid = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] addr, input logic [1:0] trans);
        chk({tag, "_addr"}, bus_if.Haddr, addr);
        chk({tag, "_trans"}, 32'(bus_if.Htrans), 32'(trans));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_htrans"},    32'(bus_if.Htrans),    32'h0);
        chk({tag, "_haddr"},     bus_if.Haddr,          32'h0);
        chk({tag, "_hburst"},    32'(bus_if.Hburst),    32'h0);
        chk({tag, "_hsize"},     32'(bus_if.Hsize),     32'h0);
        chk({tag, "_hwrite"},    32'(bus_if.Hwrite),    32'h0);
        chk({tag, "_hbusreq"},   32'(bus_if.Hbusreq),   32'h0);
        chk({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready), 32'h1);
        chk({tag, "_done"},      32'(bus_if.done),      32'h0);
        chk({tag, "_err"},       32'(bus_if.err),       32'h0);
        chk({tag, "_beat_idx"},  32'(bus_if.beat_idx),  32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Hresetn          = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_addr  = '0;
        bus_if.cmd_burst = '0;
        bus_if.cmd_size  = '0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_len   = '0;
        bus_if.Hgrant    = 1'b1;
        bus_if.Hready    = 1'b1;
        bus_if.Hresp     = HRESP_OKAY;
        repeat (3) tick();
        chk_reset("por");
        Hresetn = 1'b1;
        tick();

        // INCR4 write, zero wait, grant held
        send_cmd(32'h100, HBURST_INCR4, 3'd2, 1'b1, 5'd0);
        chk("i4_busreq_req", 32'(bus_if.Hbusreq),   32'h1);
        chk("i4_ready_req",  32'(bus_if.cmd_ready), 32'h0);
        chk("i4_trans_req",  32'(bus_if.Htrans),    32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_beat($sformatf("i4_b%0d", i), i4_a[i], i4_t[i]);
            chk($sformatf("i4_idx%0d", i), 32'(bus_if.beat_idx), i);
            chk($sformatf("i4_busreq%0d", i), 32'(bus_if.Hbusreq), (i == 3) ? 32'h0 : 32'h1);
            if (i == 0) begin
                chk("i4_hburst", 32'(bus_if.Hburst), 32'h3);
                chk("i4_hsize",  32'(bus_if.Hsize),  32'h2);
                chk("i4_hwrite", 32'(bus_if.Hwrite), 32'h1);
            end
        end
        tick();
        chk("i4_trans_last", 32'(bus_if.Htrans), 32'h0);
        chk("i4_done_early", 32'(bus_if.done),   32'h0);
        tick();
        chk("i4_done",       32'(bus_if.done),      32'h1);
        chk("i4_err",        32'(bus_if.err),       32'h0);
        chk("i4_ready_done", 32'(bus_if.cmd_ready), 32'h0);
        tick();
        chk("i4_done_clr",   32'(bus_if.done),      32'h0);
        chk("i4_ready_back", 32'(bus_if.cmd_ready), 32'h1);

        // INCR, 6 beats across the 1 KB line at 0x400
        send_cmd(32'h3F8, HBURST_INCR, 3'd2, 1'b0, 5'd5);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_beat($sformatf("incr_b%0d", i), incr_a[i], incr_t[i]);
            if (i == 0) chk("incr_hburst", 32'(bus_if.Hburst), 32'h1);
        end
        tick();
        chk("incr_trans_last", 32'(bus_if.Htrans), 32'h0);
        tick();
        chk("incr_done", 32'(bus_if.done), 32'h1);
        chk("incr_err",  32'(bus_if.err),  32'h0);
        tick();

        // INCR8 with grant loss after beat 3, regrant 4 cycles later
        send_cmd(32'h0, HBURST_INCR8, 3'd2, 1'b1, 5'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_beat($sformatf("gl_b%0d", i), gl_a[i], gl_t[i]);
        end
        bus_if.Hgrant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("gl_gap_trans%0d", i),  32'(bus_if.Htrans),  32'h0);
            chk($sformatf("gl_gap_busreq%0d", i), 32'(bus_if.Hbusreq), 32'h1);
            chk($sformatf("gl_gap_done%0d", i),   32'(bus_if.done),    32'h0);
        end
        bus_if.Hgrant = 1'b1;
        for (int i = 4; i < 8; i++) begin
            tick();
            chk_beat($sformatf("gl_b%0d", i), gl_a[i], gl_t[i]);
            chk($sformatf("gl_idx%0d", i), 32'(bus_if.beat_idx), i);
            if (i == 4) chk("gl_rebuild_hburst", 32'(bus_if.Hburst), 32'h1);
        end
        tick();
        chk("gl_done_early", 32'(bus_if.done), 32'h0);
        tick();
        chk("gl_done", 32'(bus_if.done), 32'h1);
        chk("gl_err",  32'(bus_if.err),  32'h0);
        tick();
        chk("gl_single_done", 32'(bus_if.done), 32'h0);

        // WRAP4 at 0x38
        send_cmd(32'h38, HBURST_WRAP4, 3'd2, 1'b0, 5'd0);
`ifdef AHB_SEQ_WRAP_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_beat($sformatf("wr_b%0d", i), wr_a[i], wr_t[i]);
            if (i == 0) chk("wr_hburst", 32'(bus_if.Hburst), 32'h2);
        end
        tick();
        tick();
        chk("wr_done", 32'(bus_if.done), 32'h1);
        chk("wr_err",  32'(bus_if.err),  32'h0);
        tick();
`else
        chk("wr_rej_done",   32'(bus_if.done),    32'h1);
        chk("wr_rej_err",    32'(bus_if.err),     32'h1);
        chk("wr_rej_busreq", 32'(bus_if.Hbusreq), 32'h0);
        chk("wr_rej_trans",  32'(bus_if.Htrans),  32'h0);
        tick();
        chk("wr_rej_done_clr", 32'(bus_if.done),      32'h0);
        chk("wr_rej_trans2",   32'(bus_if.Htrans),    32'h0);
`endif
        chk("wr_ready_back", 32'(bus_if.cmd_ready), 32'h1);

        // SINGLE read with one address-phase wait state
        send_cmd(32'h200, HBURST_SINGLE, 3'd1, 1'b0, 5'd0);
        tick();
        chk_beat("sg_b0", 32'h200, HTRANS_NONSEQ);
        chk("sg_hsize",  32'(bus_if.Hsize),   32'h1);
        chk("sg_hwrite", 32'(bus_if.Hwrite),  32'h0);
        chk("sg_hburst", 32'(bus_if.Hburst),  32'h0);
        chk("sg_busreq", 32'(bus_if.Hbusreq), 32'h0);
        bus_if.Hready = 1'b0;
        tick();
        chk_beat("sg_hold", 32'h200, HTRANS_NONSEQ);
        bus_if.Hready = 1'b1;
        tick();
        chk("sg_trans_last", 32'(bus_if.Htrans), 32'h0);
        tick();
        chk("sg_done",  32'(bus_if.done),      32'h1);
        chk("sg_err",   32'(bus_if.err),       32'h0);
        chk("sg_ready", 32'(bus_if.cmd_ready), 32'h0);
        tick();
        chk("sg_ready_back", 32'(bus_if.cmd_ready), 32'h1);

        // INCR4 with ERROR on the second beat's data phase
        send_cmd(32'h100, HBURST_INCR4, 3'd2, 1'b1, 5'd0);
        tick();
        tick();
        tick();
        chk_beat("er_b2", 32'h108, HTRANS_SEQ);
        bus_if.Hready = 1'b0;
        bus_if.Hresp  = HRESP_ERROR;
        tick();
        chk("er_trans_idle", 32'(bus_if.Htrans), 32'h0);
        chk("er_done_early", 32'(bus_if.done),   32'h0);
        bus_if.Hready = 1'b1;
        tick();
        chk("er_done",   32'(bus_if.done),    32'h1);
        chk("er_err",    32'(bus_if.err),     32'h1);
        chk("er_busreq", 32'(bus_if.Hbusreq), 32'h0);
        bus_if.Hresp = HRESP_OKAY;
        tick();
        chk("er_done_clr",   32'(bus_if.done),      32'h0);
        chk("er_ready_back", 32'(bus_if.cmd_ready), 32'h1);

        // reset during beat 2 of INCR16
        send_cmd(32'h400, HBURST_INCR16, 3'd2, 1'b1, 5'd0);
        tick();
        tick();
        chk_beat("rs_b1", 32'h404, HTRANS_SEQ);
        Hresetn = 1'b0;
        tick();
        chk_reset("mid_rst");
        Hresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rs_no_done%0d", i), 32'(bus_if.done),   32'h0);
            chk($sformatf("rs_idle%0d", i),    32'(bus_if.Htrans), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
